// File: rtl/blk_995ec5_if.sv
// ---------------------------------------------------------------------------
// blk_995ec5_if
// Word-wide request/acknowledge port between the debug OCI memory sequencer
// and the on-chip memory it accesses.
//
// Signals
//   mem_addr   ADDR_W  word address, held stable while a request is pending
//   mem_wdata  32      write data, held stable while a request is pending
//   mem_read   1       read request, held until mem_ack
//   mem_write  1       write request, held until mem_ack
//   mem_rdata  32      read data, valid when mem_ack=1 during a read
//   mem_ack    1       transaction complete
//
// Modports
//   master  sequencer side (drives requests, receives ack/rdata)
//   slave   memory side
// ---------------------------------------------------------------------------
interface blk_995ec5_if #(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_read,
    output mem_write,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_read,
    input  mem_write,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/blk_995ec5.sv
// ---------------------------------------------------------------------------
// blk_995ec5
// Sysclk-domain sequencer for debug on-chip-memory (OCI) access commands.
// Decodes the debug slave's command strobes and jdo payload, runs single-word
// read/write transactions on a req/ack memory port with address
// auto-increment and an acknowledge timeout, and returns the result.
//
// Ports
//   clk                      in   1       system clock
//   reset                    in   1       asynchronous reset, active-high
//   jdo                      in   38      command payload from the debug slave
//   take_action_ocimem_a     in   1       strobe: load address, optional read
//   take_action_ocimem_b     in   1       strobe: write jdo[34:3] at current address
//   take_no_action_ocimem_a  in   1       strobe: read at current address
//   mem                      master       OCI memory request/ack port
//   MonDReg                  out  32      last read data / last written data
//   monitor_ready            out  1       last command finished, result valid
//   monitor_error            out  1       last command timed out
//   cmd_overrun              out  1       sticky: strobe arrived while busy
//   busy                     out  1       transaction in progress
// ---------------------------------------------------------------------------
module blk_995ec5 #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [37:0]         jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  blk_995ec5_if.master        mem,
  output logic [31:0]         MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  output logic                cmd_overrun,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mon_q,   mon_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              ovr_q,   ovr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic any_strobe;
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                      take_no_action_ocimem_a;

  // jdo[37:36] and jdo[2:0] carry nothing this sequencer acts on.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
    ready_d = ready_q;
    error_d = error_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, ERR: begin
        // Priority b > a > no_action_a; losers are simply ignored.
        if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          mon_d   = jdo[34:3];
          ready_d = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
          state_d = WR;
        end else if (take_action_ocimem_a) begin
          addr_d  = jdo[17 +: ADDR_W];
          error_d = 1'b0;
          cnt_d   = '0;
          if (jdo[35]) begin
            ready_d = 1'b0;
            state_d = RD;
          end else begin
            // Address-only load finishes at once.
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end else if (take_no_action_ocimem_a) begin
          ready_d = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
          state_d = RD;
        end
      end

      RD, WR: begin
        // Strobes while busy are dropped; only the sticky flag records them.
        if (any_strobe) begin
          ovr_d = 1'b1;
        end
        if (mem.mem_ack) begin
          if (state_q == RD) begin
            mon_d = mem.mem_rdata;
          end
          addr_d  = addr_q + ADDR_W'(1);
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // cnt_q counts earlier unacknowledged cycles, so this is the
          // TIMEOUT-th cycle without ack; an ack here would have won above.
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mon_q   <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
      ready_q <= ready_d;
      error_q <= error_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Requests decode straight from the state register, so an asynchronous
  // reset drops them immediately.
  assign mem.mem_read   = (state_q == RD);
  assign mem.mem_write  = (state_q == WR);
  assign mem.mem_addr   = addr_q;
  assign mem.mem_wdata  = wdata_q;
  assign busy           = (state_q == RD) || (state_q == WR);
  assign MonDReg        = mon_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;
  assign cmd_overrun    = ovr_q;

endmodule

// File: tb/tb_blk_995ec5.sv
// ---------------------------------------------------------------------------
// tb_blk_995ec5
// Directed bench for the OCI memory sequencer. A transaction-level model
// tracks what the outputs must be; a compare process checks the DUT against
// it on every falling edge, and the directed scenarios pin the model with
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_blk_995ec5;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_b, take_na;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, cmd_overrun, busy;

  int n_vec = 0;
  int n_err = 0;

  blk_995ec5_if #(.ADDR_W(8)) mem_if ();

  blk_995ec5 #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .mem                     (mem_if),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .cmd_overrun             (cmd_overrun),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  localparam int K_NONE = 0, K_RD = 1, K_WR = 2;
  int          m_kind;
  int          m_waited;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_mon;
  bit          m_ready, m_err, m_ovr;

  task automatic model_reset();
    m_kind = K_NONE; m_waited = 0; m_addr = 8'h00;
    m_wdata = '0; m_mon = '0; m_ready = 0; m_err = 0; m_ovr = 0;
  endtask

  // Advances the model by one clock using the inputs the DUT will sample.
  task automatic model_step();
    bit any;
    any = take_a | take_b | take_na;
    if (m_kind != K_NONE) begin
      if (any) m_ovr = 1;
      if (mem_if.mem_ack) begin
        if (m_kind == K_RD) m_mon = mem_if.mem_rdata;
        m_addr  = 8'((int'(m_addr) + 1) % 256);
        m_ready = 1;
        m_kind  = K_NONE;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_kind = K_NONE; m_err = 1; m_ready = 1;
        end
      end
    end else if (any) begin
      m_ready = 0; m_err = 0; m_waited = 0;
      if (take_b) begin
        m_wdata = jdo[34:3]; m_mon = jdo[34:3]; m_kind = K_WR;
      end else if (take_a) begin
        m_addr = jdo[24:17];
        if (jdo[35]) m_kind = K_RD;
        else         m_ready = 1;
      end else begin
        m_kind = K_RD;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      check("cmp_read",    mem_if.mem_read,  m_kind == K_RD);
      check("cmp_write",   mem_if.mem_write, m_kind == K_WR);
      check("cmp_busy",    busy,             m_kind != K_NONE);
      check("cmp_addr",    mem_if.mem_addr,  m_addr);
      check("cmp_wdata",   mem_if.mem_wdata, m_wdata);
      check("cmp_mondreg", MonDReg,          m_mon);
      check("cmp_ready",   monitor_ready,    m_ready);
      check("cmp_error",   monitor_error,    m_err);
      check("cmp_overrun", cmd_overrun,      m_ovr);
      if (!reset) model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic [7:0] addr, input logic rd);
    jdo = '0; jdo[35] = rd; jdo[24:17] = addr;
    take_a = 1'b1; tick(); take_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] data);
    jdo = '0; jdo[34:3] = data;
    take_b = 1'b1; tick(); take_b = 1'b0;
  endtask

  task automatic strobe_na();
    take_na = 1'b1; tick(); take_na = 1'b0;
  endtask

  task automatic ack_cycle(input logic [31:0] rdata);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = rdata;
    tick();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    reset = 1'b1; jdo = '0; take_a = 0; take_b = 0; take_na = 0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    tick(); tick();
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_addr",    mem_if.mem_addr, 8'h00);
    check("rst_busy",    busy, 1'b0);
    reset = 1'b0;
    tick();

    // 1. read at 0x10, ack two cycles after the strobe
    strobe_a(8'h10, 1'b1);
    check("t1_read",  mem_if.mem_read, 1'b1);
    check("t1_addr",  mem_if.mem_addr, 8'h10);
    check("t1_ready_cleared", monitor_ready, 1'b0);
    tick();
    ack_cycle(32'hDEADBEEF);
    check("t1_mondreg", MonDReg, 32'hDEADBEEF);
    check("t1_ready",   monitor_ready, 1'b1);
    check("t1_addr_inc", mem_if.mem_addr, 8'h11);
    check("t1_read_low", mem_if.mem_read, 1'b0);

    // 2. write at 0x11, immediate ack
    strobe_b(32'h12345678);
    check("t2_write", mem_if.mem_write, 1'b1);
    check("t2_wdata", mem_if.mem_wdata, 32'h12345678);
    check("t2_addr",  mem_if.mem_addr, 8'h11);
    ack_cycle(32'hFFFFFFFF);
    check("t2_ready",   monitor_ready, 1'b1);
    check("t2_write_low", mem_if.mem_write, 1'b0);
    check("t2_addr_inc", mem_if.mem_addr, 8'h12);
    check("t2_mondreg", MonDReg, 32'h12345678);

    // Address-only load: ready next cycle, no request.
    strobe_a(8'h40, 1'b0);
    check("ld_ready", monitor_ready, 1'b1);
    check("ld_busy",  busy, 1'b0);
    check("ld_addr",  mem_if.mem_addr, 8'h40);

    // 3. wrap from 0xFF, then no_action read at 0x00
    strobe_a(8'hFF, 1'b1);
    ack_cycle(32'h0000_00FF);
    check("t3_wrap", mem_if.mem_addr, 8'h00);
    strobe_na();
    check("t3_na_read", mem_if.mem_read, 1'b1);
    check("t3_na_addr", mem_if.mem_addr, 8'h00);
    ack_cycle(32'h0BAD_F00D);
    check("t3_na_data", MonDReg, 32'h0BAD_F00D);
    check("t3_na_addr_inc", mem_if.mem_addr, 8'h01);

    // 4a. timeout: request must be held for exactly TIMEOUT cycles
    strobe_a(8'h20, 1'b1);
    waits = 0;
    while (mem_if.mem_read && waits < 300) begin
      waits++;
      tick();
    end
    check("t4_wait_cycles", waits, TIMEOUT);
    check("t4_error",   monitor_error, 1'b1);
    check("t4_ready",   monitor_ready, 1'b1);
    check("t4_addr",    mem_if.mem_addr, 8'h20);
    check("t4_mondreg", MonDReg, 32'h0BAD_F00D);
    strobe_a(8'h30, 1'b0);
    check("t4_err_clr", monitor_error, 1'b0);
    // 4b. ack on the expiry cycle wins
    strobe_a(8'h30, 1'b1);
    repeat (TIMEOUT - 1) tick();
    check("t4b_still_read", mem_if.mem_read, 1'b1);
    ack_cycle(32'h5555AAAA);
    check("t4b_error", monitor_error, 1'b0);
    check("t4b_ready", monitor_ready, 1'b1);
    check("t4b_addr",  mem_if.mem_addr, 8'h31);
    check("t4b_data",  MonDReg, 32'h5555AAAA);

    // 5. write strobe while reading is dropped and flagged
    strobe_a(8'h50, 1'b1);
    jdo = '0; jdo[34:3] = 32'h77777777;
    take_b = 1'b1; tick(); take_b = 1'b0;
    check("t5_overrun", cmd_overrun, 1'b1);
    check("t5_no_write", mem_if.mem_write, 1'b0);
    check("t5_read", mem_if.mem_read, 1'b1);
    ack_cycle(32'h13572468);
    check("t5_data", MonDReg, 32'h13572468);
    check("t5_addr", mem_if.mem_addr, 8'h51);
    check("t5_wdata_kept", mem_if.mem_wdata, 32'h12345678);
    // a and b together: write only, address untouched
    jdo = '0; jdo[35] = 1'b1; jdo[34:3] = 32'hCAFEF00D;
    take_a = 1'b1; take_b = 1'b1; tick(); take_a = 1'b0; take_b = 1'b0;
    check("t5_ab_write", mem_if.mem_write, 1'b1);
    check("t5_ab_read",  mem_if.mem_read, 1'b0);
    check("t5_ab_addr",  mem_if.mem_addr, 8'h51);
    check("t5_ab_wdata", mem_if.mem_wdata, 32'hCAFEF00D);
    ack_cycle(32'h0);
    check("t5_ab_addr_inc", mem_if.mem_addr, 8'h52);
    check("t5_overrun_sticky", cmd_overrun, 1'b1);

    // 6. reset in the middle of a write
    strobe_b(32'hA5A5A5A5);
    check("t6_write", mem_if.mem_write, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_write_drop", mem_if.mem_write, 1'b0);
    check("t6_addr",    mem_if.mem_addr, 8'h00);
    check("t6_wdata",   mem_if.mem_wdata, 32'h0);
    check("t6_mondreg", MonDReg, 32'h0);
    check("t6_overrun", cmd_overrun, 1'b0);
    check("t6_ready",   monitor_ready, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    strobe_a(8'h05, 1'b1);
    check("t6_after_read", mem_if.mem_read, 1'b1);
    ack_cycle(32'h600DCAFE);
    check("t6_after_data", MonDReg, 32'h600DCAFE);
    check("t6_after_addr", mem_if.mem_addr, 8'h06);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
